// File: rtl/note_sequencer.sv
// Song-RAM driven note sequencer: plays {note, dur} entries in order, each held for
// dur ticks, with optional silent gap between entries, end-of-song markers and looping.
module note_sequencer #(
    parameter int CLK_HZ    = 100000000,
    parameter int TICK_HZ   = 1000,
    parameter int GAP_TICKS = 0,
    parameter int DEPTH     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_data,
    output logic [7:0]               note,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] idx
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);
    localparam int CNT_W  = (GAP_W > 8) ? GAP_W : 8;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  GAP_CNT  = CNT_W'(GAP_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         note_q, note_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [15:0]        mem [DEPTH];
    logic [15:0]        rd_q;
    logic [7:0]         entry_note;
    logic [7:0]         entry_dur;
    logic [7:0]         mapped_note;
    logic               advance;
    logic               end_of_song;

    // Song RAM: the read port follows idx every cycle; only the value latched during FETCH is consumed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[idx_q];
    end

    assign entry_note  = rd_q[15:8];
    assign entry_dur   = rd_q[7:0];
    assign mapped_note = (entry_note == 8'd0 || entry_note > 8'd96) ? 8'd0 : entry_note;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            note_q  <= 8'd0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        done_d      = 1'b0;
        idx_d       = idx_q;
        pre_d       = pre_q;
        cnt_d       = cnt_q;
        advance     = 1'b0;
        end_of_song = 1'b0;

        if (state_q != IDLE && stop) begin
            state_d = IDLE;
            note_d  = 8'd0;
            idx_d   = '0;
            pre_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    note_d = 8'd0;
                    if (start && !stop) begin
                        state_d = FETCH;
                        idx_d   = '0;
                    end
                end
                FETCH: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    if (entry_dur != 8'd0) begin
                        state_d = PLAY;
                        note_d  = mapped_note;
                        cnt_d   = CNT_W'(entry_dur);
                        pre_d   = '0;
                    end else begin
                        end_of_song = 1'b1;
                    end
                end
                PLAY, GAP: begin
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        // Decrement saturates at zero; the segment ends on the wrap that consumes the last tick.
                        if (cnt_q > CNT_W'(1)) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            cnt_d = '0;
                            if (state_q == PLAY && GAP_TICKS > 0) begin
                                state_d = GAP;
                                note_d  = 8'd0;
                                cnt_d   = GAP_CNT;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    note_d  = 8'd0;
                end
            endcase

            if (advance) begin
                if (idx_q == IDX_LAST) begin
                    end_of_song = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end

            // A marker at entry 0 always finishes, so an empty song cannot loop forever.
            if (end_of_song) begin
                if (loop_en && idx_q != '0) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                    note_d  = 8'd0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end
            end
        end
    end

    assign note = note_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign idx  = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (no gap / one-tick gap) share stimulus and are
// compared cycle by cycle against a trace computed from the song contents.
module tb_note_sequencer;

    localparam int DIV   = 10;
    localparam int DEPTH = 8;
    localparam int MAXS  = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [15:0] wr_data = 16'd0;

    logic [7:0]  note_o [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic [2:0]  idx_o  [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] song [DEPTH];
    int exp_note [2][MAXS];
    int exp_busy [2][MAXS];
    int exp_done [2][MAXS];
    int exp_idx  [2][MAXS];
    int exp_len  [2];

    always #5 clk = ~clk;

    note_sequencer #(.CLK_HZ(10), .TICK_HZ(1), .GAP_TICKS(0), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .note(note_o[0]), .busy(busy_o[0]), .done(done_o[0]), .idx(idx_o[0])
    );

    note_sequencer #(.CLK_HZ(10), .TICK_HZ(1), .GAP_TICKS(1), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .note(note_o[1]), .busy(busy_o[1]), .done(done_o[1]), .idx(idx_o[1])
    );

    function automatic int map_note(input int n);
        return (n == 0 || n > 96) ? 0 : n;
    endfunction

    function automatic void push(input int d, input int n, input int b, input int dn, input int ix);
        if (exp_len[d] < MAXS) begin
            exp_note[d][exp_len[d]] = n;
            exp_busy[d][exp_len[d]] = b;
            exp_done[d][exp_len[d]] = dn;
            exp_idx[d][exp_len[d]]  = ix;
            exp_len[d]++;
        end
    endfunction

    // Expected sample i+1 after the start edge; loop_en is high at decisions made before sample loop_until.
    function automatic void build(input int d, input int g, input int loop_until);
        int  held = 0;
        int  ix   = 0;
        int  dur;
        int  nn;
        bit  fin  = 0;
        exp_len[d] = 0;
        while (!fin && exp_len[d] < MAXS - 200) begin
            push(d, held, 1, 0, ix);
            push(d, held, 1, 0, ix);
            dur = int'(song[ix][7:0]);
            nn  = map_note(int'(song[ix][15:8]));
            if (dur == 0) begin
                if (exp_len[d] < loop_until && ix != 0) begin
                    ix = 0;
                end else begin
                    push(d, 0, 0, 1, -1);
                    fin = 1;
                end
            end else begin
                for (int t = 0; t < dur * DIV; t++) push(d, nn, 1, 0, ix);
                held = nn;
                for (int t = 0; t < g * DIV; t++) push(d, 0, 1, 0, ix);
                if (g > 0) held = 0;
                if (ix == DEPTH - 1) begin
                    if (exp_len[d] < loop_until) begin
                        ix = 0;
                    end else begin
                        push(d, 0, 0, 1, -1);
                        fin = 1;
                    end
                end else begin
                    ix++;
                end
            end
        end
        for (int t = 0; t < 3; t++) push(d, 0, 0, 0, -1);
    endfunction

    task automatic write_entry(input int a, input logic [15:0] v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = v;
        song[a] = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic run_song(input string name, input int loop_until, input int wr_at,
                            input int wr_a, input logic [15:0] wr_d);
        int len;
        build(0, 0, loop_until);
        build(1, 1, loop_until);
        len = (exp_len[0] > exp_len[1]) ? exp_len[0] : exp_len[1];
        @(negedge clk);
        start   = 1'b1;
        loop_en = (loop_until > 0);
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            if (j == 2) start = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (j <= exp_len[d]) begin
                    n_checks++;
                    if (note_o[d] !== 8'(exp_note[d][j-1]) || busy_o[d] !== 1'(exp_busy[d][j-1])
                        || done_o[d] !== 1'(exp_done[d][j-1])) begin
                        n_fail++;
                        $display("FAIL %s gap%0d sample %0d: note/busy/done got %0d/%0d/%0d want %0d/%0d/%0d",
                                 name, d, j, note_o[d], busy_o[d], done_o[d],
                                 exp_note[d][j-1], exp_busy[d][j-1], exp_done[d][j-1]);
                    end
                    if (exp_idx[d][j-1] >= 0) begin
                        n_checks++;
                        if (idx_o[d] !== 3'(exp_idx[d][j-1])) begin
                            n_fail++;
                            $display("FAIL %s gap%0d sample %0d idx: got %0d want %0d",
                                     name, d, j, idx_o[d], exp_idx[d][j-1]);
                        end
                    end
                end
            end
            if (wr_at == j) begin
                wr_en   = 1'b1;
                wr_addr = 3'(wr_a);
                wr_data = wr_d;
            end else begin
                wr_en = 1'b0;
            end
            loop_en = (j < loop_until);
        end
        wr_en   = 1'b0;
        loop_en = 1'b0;
        if (wr_at > 0) song[wr_a] = wr_d;
        $display("song %s: %0d samples, checks %0d, failures so far %0d", name, len, n_checks, n_fail);
    endtask

    task automatic check_idle_outputs(input string name);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (note_o[d] !== 8'd0 || busy_o[d] !== 1'b0 || done_o[d] !== 1'b0 || idx_o[d] !== 3'd0) begin
                n_fail++;
                $display("FAIL %s gap%0d: note/busy/done/idx got %0d/%0d/%0d/%0d want 0/0/0/0",
                         name, d, note_o[d], busy_o[d], done_o[d], idx_o[d]);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        check_idle_outputs("reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_released");
        $display("test_reset done");
    endtask

    task automatic test_single();
        write_entry(0, {8'd49, 8'd3});
        write_entry(1, 16'd0);
        // Rewrite entry 0 while it plays: current note must be unaffected.
        run_song("single", 0, 10, 0, {8'd60, 8'd1});
        run_song("rewritten", 0, 0, 0, 16'd0);
    endtask

    task automatic test_gap();
        write_entry(0, {8'd10, 8'd1});
        write_entry(1, {8'd20, 8'd2});
        write_entry(2, 16'd0);
        run_song("two_notes", 0, 0, 0, 16'd0);
    endtask

    task automatic test_loop();
        run_song("loop", 120, 0, 0, 16'd0);
    endtask

    task automatic test_rest();
        write_entry(0, {8'd200, 8'd2});
        write_entry(1, {8'd97, 8'd1});
        write_entry(2, 16'd0);
        run_song("rest", 0, 0, 0, 16'd0);
    endtask

    task automatic test_stop();
        write_entry(0, {8'd49, 8'd3});
        write_entry(1, 16'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_idle_outputs("stop_mid_play");
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (done_o[d] !== 1'b0 || busy_o[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL after_stop gap%0d cycle %0d: done/busy got %0d/%0d want 0/0",
                             d, j, done_o[d], busy_o[d]);
                end
            end
        end
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_idle_outputs("start_with_stop");
        @(negedge clk);
        check_idle_outputs("start_with_stop_next");
        $display("test_stop done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (busy_o[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL start_after_reset gap%0d: busy got %0d want 1", d, busy_o[d]);
            end
        end
        repeat (80) @(negedge clk);
        check_idle_outputs("after_restart");
        $display("test_reset_mid done");
    endtask

    task automatic test_full();
        for (int a = 0; a < DEPTH; a++) begin
            write_entry(a, {8'($urandom_range(1, 96)), 8'($urandom_range(1, 2))});
        end
        run_song("full", 0, 0, 0, 16'd0);
    endtask

    task automatic test_random();
        int lu;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if ($urandom_range(0, 4) == 0)
                    write_entry(a, {8'($urandom_range(0, 255)), 8'd0});
                else
                    write_entry(a, {8'($urandom_range(0, 255)), 8'($urandom_range(1, 3))});
            end
            lu = ($urandom_range(0, 1) == 1) ? int'($urandom_range(50, 200)) : 0;
            run_song($sformatf("random%0d", it), lu, 0, 0, 16'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) song[a] = 16'd0;
        test_reset();
        test_single();
        test_gap();
        test_loop();
        test_rest();
        test_stop();
        test_reset_mid();
        test_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
